silpa_fpga_core: RTL and testbench

FPGA top-level register block with an SPI slave host interface (SPI0), a 16-bit bidirectional GPIO slot, and a configurable SPI master driving the SD-card pins.
- Host frame: 8-bit address, 8 dummy clocks, then 16-bit data.
- Host reads and writes a flat 16-bit register map.
- All logic runs in the single clk480 domain; SPI0 inputs are oversampled.

---
 rtl/silpa_pkg.sv | 30 +++
 rtl/silpa_spi_master.sv | 114 +++++++++++
 rtl/silpa_fpga_core.sv | 223 ++++++++++++++++++++++
 tb/tb_silpa_fpga_core.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/silpa_pkg.sv
// rtl/silpa_pkg.sv - register map, host frame constants and SPI master state type
package silpa_pkg;

    localparam int READ_FLAG = 7;

    localparam logic [6:0] ADDR_SLOT_OUT    = 7'h00;
    localparam logic [6:0] ADDR_SLOT_DIR    = 7'h01;
    localparam logic [6:0] ADDR_SLOT_IN     = 7'h02;
    localparam logic [6:0] ADDR_TXRX        = 7'h03;
    localparam logic [6:0] ADDR_LENGTH      = 7'h04;
    localparam logic [6:0] ADDR_CS_MASK     = 7'h05;
    localparam logic [6:0] ADDR_CS_POL      = 7'h06;
    localparam logic [6:0] ADDR_CLKDIV      = 7'h07;
    localparam logic [6:0] ADDR_OFFLINE     = 7'h08;
    localparam logic [6:0] ADDR_CPOL        = 7'h09;
    localparam logic [6:0] ADDR_CPHA        = 7'h0A;
    localparam logic [6:0] ADDR_LSB_FIRST   = 7'h0B;
    localparam logic [6:0] ADDR_HALF_DUPLEX = 7'h0C;
    localparam logic [6:0] ADDR_END         = 7'h0D;
    localparam logic [6:0] ADDR_WRITABLE    = 7'h0F;
    localparam logic [6:0] ADDR_IDLE        = 7'h10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_SHIFT,
        ST_DONE
    } spim_state_e;

endpackage

// File: rtl/silpa_spi_master.sv
// rtl/silpa_spi_master.sv - SD-card SPI master: FSM, clock divider, TX/RX shifter
module silpa_spi_master
    import silpa_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [15:0] tx_data_i,
    input  logic [3:0]  length_i,
    input  logic        cs_mask_i,
    input  logic        cs_pol_i,
    input  logic [7:0]  clkdiv_i,
    input  logic        offline_i,
    input  logic        cpol_i,
    input  logic        cpha_i,
    input  logic        lsb_first_i,
    input  logic        half_duplex_i,
    input  logic        end_i,
    input  logic        miso_i,
    output logic        idle_o,
    output logic        done_o,
    output logic [15:0] rx_data_o,
    output logic        sck_o,
    output logic        mosi_o,
    output logic        cs_n_o
);

    spim_state_e state_q, state_d;
    logic [3:0]  len_q;
    logic [7:0]  div_q, div_cnt_q;
    logic [4:0]  edge_q;
    logic [15:0] txsh_q, rxsh_q, rx_q;
    logic        cs_pol_q, cpha_q, lsb_q, hd_q, end_q, sck_q, cs_act_q;
    logic        running, tick, sh_tick, leading, last_edge, shift_tx, sample;

    assign running   = (state_q == ST_ASSERT) || (state_q == ST_SHIFT);
    assign tick      = running && (div_cnt_q == div_q - 8'd1);
    assign sh_tick   = tick && (state_q == ST_SHIFT);
    assign leading   = ~edge_q[0];
    assign last_edge = (edge_q == {len_q, 1'b1});
    // CPHA=1 launches bit 0 before the first edge, so its first leading edge must not shift
    assign shift_tx  = sh_tick && (cpha_q ? (leading && (edge_q != 5'd0)) : !leading);
    assign sample    = sh_tick && (cpha_q ? !leading : leading);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_i) state_d = ST_ASSERT;
            ST_ASSERT: if (tick) state_d = ST_SHIFT;
            ST_SHIFT:  if (sh_tick && last_edge) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_q     <= '0;
            div_q     <= 8'd1;
            div_cnt_q <= '0;
            edge_q    <= '0;
            txsh_q    <= '0;
            rxsh_q    <= '0;
            rx_q      <= '0;
            cs_pol_q  <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            hd_q      <= 1'b0;
            end_q     <= 1'b0;
            sck_q     <= 1'b0;
            cs_act_q  <= 1'b0;
        end else begin
            // configuration is snapshotted here so mid-transfer writes only affect the next one
            if (state_q == ST_IDLE && start_i) begin
                len_q    <= length_i;
                div_q    <= (clkdiv_i == 8'd0) ? 8'd1 : clkdiv_i;
                cs_pol_q <= cs_pol_i;
                cpha_q   <= cpha_i;
                lsb_q    <= lsb_first_i;
                hd_q     <= half_duplex_i;
                end_q    <= end_i;
                txsh_q   <= lsb_first_i ? tx_data_i : (tx_data_i << (4'd15 - length_i));
                rxsh_q   <= '0;
                sck_q    <= cpol_i;
                cs_act_q <= cs_mask_i;
                edge_q   <= '0;
            end
            div_cnt_q <= (running && !tick) ? div_cnt_q + 8'd1 : 8'd0;
            if (sh_tick) begin
                sck_q  <= ~sck_q;
                edge_q <= edge_q + 5'd1;
            end
            if (shift_tx) txsh_q <= lsb_q ? (txsh_q >> 1) : (txsh_q << 1);
            if (sample)   rxsh_q <= lsb_q ? {miso_i, rxsh_q[15:1]} : {rxsh_q[14:0], miso_i};
            if (state_q == ST_DONE) begin
                rx_q <= hd_q ? 16'd0 : (lsb_q ? (rxsh_q >> (4'd15 - len_q)) : rxsh_q);
                if (end_q) cs_act_q <= 1'b0;
            end
        end
    end

    assign idle_o    = (state_q == ST_IDLE);
    assign done_o    = (state_q == ST_DONE);
    assign rx_data_o = rx_q;
    assign sck_o     = sck_q;
    assign mosi_o    = lsb_q ? txsh_q[0] : txsh_q[15];
    assign cs_n_o    = (cs_act_q && !offline_i) ? cs_pol_q : !cs_pol_q;

endmodule

// File: rtl/silpa_fpga_core.sv
// rtl/silpa_fpga_core.sv - host SPI slave, register file, GPIO slot; SPIM_LSB_FIRST_EN enables LSB_FIRST
module silpa_fpga_core
    import silpa_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int DUMMY_CYCLES = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              clk480,
    input  logic              sys_rst_n,
    input  logic              spi0_clk,
    input  logic              spi0_mosi,
    output logic              spi0_miso,
    input  logic              spi0_cs_n,
    inout  wire  [DATA_W-1:0] slot,
    output logic              user_led,
    output logic              user_led_1,
    output logic              user_led_2,
    output logic              spisdcard_clk,
    output logic              spisdcard_mosi,
    output logic              spisdcard_cs_n,
    input  logic              spisdcard_miso
);

    localparam int FRAME_BITS = ADDR_W + DUMMY_CYCLES + DATA_W;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(ADDR_W + DUMMY_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(FRAME_BITS);

    logic [SYNC_STAGES-1:0]             sck_sq, mosi_sq, cs_sq;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] slot_sq;
    logic sck_prev_q, sck_s, mosi_s, cs_s, rise, fall;
    logic [DATA_W-1:0] slot_in_s;

    always_ff @(posedge clk480 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sck_sq     <= '0;
            mosi_sq    <= '0;
            cs_sq      <= '1;
            slot_sq    <= '0;
            sck_prev_q <= 1'b0;
        end else begin
            sck_sq     <= {sck_sq[SYNC_STAGES-2:0], spi0_clk};
            mosi_sq    <= {mosi_sq[SYNC_STAGES-2:0], spi0_mosi};
            cs_sq      <= {cs_sq[SYNC_STAGES-2:0], spi0_cs_n};
            slot_sq    <= {slot_sq[SYNC_STAGES-2:0], slot};
            sck_prev_q <= sck_s;
        end
    end

    assign sck_s     = sck_sq[SYNC_STAGES-1];
    assign mosi_s    = mosi_sq[SYNC_STAGES-1];
    assign cs_s      = cs_sq[SYNC_STAGES-1];
    assign slot_in_s = slot_sq[SYNC_STAGES-1];
    assign rise      = sck_s && !sck_prev_q;
    assign fall      = !sck_s && sck_prev_q;

    logic [CNT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] shin_q, shout_q, wdata_q, rd_val, spim_rx;
    logic [ADDR_W-2:0] addr_q, rd_addr;
    logic is_rd_q, commit_q, miso_q, rd_flag, rx_clr, irq_q;
    logic spim_idle, spim_done, spim_start;

    assign rd_addr = {shin_q[ADDR_W-3:0], mosi_s};
    assign rd_flag = shin_q[READ_FLAG-1];
    assign rx_clr  = !cs_s && rise && (bit_cnt_q == CNT_ADDR) && rd_flag && (rd_addr == ADDR_TXRX);

    always_ff @(posedge clk480 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bit_cnt_q <= '0;
            shin_q    <= '0;
            shout_q   <= '0;
            wdata_q   <= '0;
            addr_q    <= '0;
            is_rd_q   <= 1'b0;
            commit_q  <= 1'b0;
            miso_q    <= 1'b0;
        end else begin
            commit_q <= 1'b0;
            if (cs_s) begin
                bit_cnt_q <= '0;
                miso_q    <= 1'b0;
            end else begin
                if (rise && bit_cnt_q != CNT_END) begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    shin_q    <= {shin_q[DATA_W-2:0], mosi_s};
                    if (bit_cnt_q == CNT_ADDR) begin
                        addr_q  <= rd_addr;
                        is_rd_q <= rd_flag;
                        shout_q <= rd_flag ? rd_val : '0;
                    end
                    if (bit_cnt_q == CNT_LAST && !is_rd_q) begin
                        commit_q <= 1'b1;
                        wdata_q  <= {shin_q[DATA_W-2:0], mosi_s};
                    end
                end
                // MISO leads the data phase by launching on the final dummy falling edge
                if (fall) begin
                    if (bit_cnt_q >= CNT_DATA && bit_cnt_q < CNT_END) begin
                        miso_q  <= shout_q[DATA_W-1];
                        shout_q <= shout_q << 1;
                    end else begin
                        miso_q <= 1'b0;
                    end
                end
            end
        end
    end

    logic [DATA_W-1:0] slot_out_q, slot_dir_q;
    logic [3:0] length_q;
    logic [7:0] clkdiv_q;
    logic cs_mask_q, cs_pol_q, offline_q, cpol_q, cpha_q, hd_q, end_q, lsb_first;

`ifdef SPIM_LSB_FIRST_EN
    logic lsb_first_q;
    assign lsb_first = lsb_first_q;
`else
    assign lsb_first = 1'b0;
`endif

    assign spim_start = commit_q && (addr_q == ADDR_TXRX) && spim_idle && !offline_q;

    always_ff @(posedge clk480 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            slot_out_q  <= '0;
            slot_dir_q  <= '0;
            length_q    <= '0;
            clkdiv_q    <= 8'd1;
            cs_mask_q   <= 1'b0;
            cs_pol_q    <= 1'b0;
            offline_q   <= 1'b0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            hd_q        <= 1'b0;
            end_q       <= 1'b0;
            irq_q       <= 1'b0;
`ifdef SPIM_LSB_FIRST_EN
            lsb_first_q <= 1'b0;
`endif
        end else begin
            irq_q <= spim_done ? 1'b1 : (rx_clr ? 1'b0 : irq_q);
            if (commit_q) begin
                case (addr_q)
                    ADDR_SLOT_OUT:    slot_out_q  <= wdata_q;
                    ADDR_SLOT_DIR:    slot_dir_q  <= wdata_q;
                    ADDR_LENGTH:      length_q    <= wdata_q[3:0];
                    ADDR_CS_MASK:     cs_mask_q   <= wdata_q[0];
                    ADDR_CS_POL:      cs_pol_q    <= wdata_q[0];
                    ADDR_CLKDIV:      clkdiv_q    <= wdata_q[7:0];
                    ADDR_OFFLINE:     offline_q   <= wdata_q[0];
                    ADDR_CPOL:        cpol_q      <= wdata_q[0];
                    ADDR_CPHA:        cpha_q      <= wdata_q[0];
`ifdef SPIM_LSB_FIRST_EN
                    ADDR_LSB_FIRST:   lsb_first_q <= wdata_q[0];
`endif
                    ADDR_HALF_DUPLEX: hd_q        <= wdata_q[0];
                    ADDR_END:         end_q       <= wdata_q[0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (rd_addr)
            ADDR_SLOT_OUT:            rd_val      = slot_out_q;
            ADDR_SLOT_DIR:            rd_val      = slot_dir_q;
            ADDR_SLOT_IN:             rd_val      = slot_in_s;
            ADDR_TXRX:                rd_val      = spim_rx;
            ADDR_LENGTH:              rd_val[3:0] = length_q;
            ADDR_CS_MASK:             rd_val[0]   = cs_mask_q;
            ADDR_CS_POL:              rd_val[0]   = cs_pol_q;
            ADDR_CLKDIV:              rd_val[7:0] = clkdiv_q;
            ADDR_OFFLINE:             rd_val[0]   = offline_q;
            ADDR_CPOL:                rd_val[0]   = cpol_q;
            ADDR_CPHA:                rd_val[0]   = cpha_q;
            ADDR_LSB_FIRST:           rd_val[0]   = lsb_first;
            ADDR_HALF_DUPLEX:         rd_val[0]   = hd_q;
            ADDR_END:                 rd_val[0]   = end_q;
            ADDR_WRITABLE, ADDR_IDLE: rd_val[0]   = spim_idle;
            default: ;
        endcase
    end

    for (genvar i = 0; i < DATA_W; i++) begin : g_slot
        assign slot[i] = slot_dir_q[i] ? slot_out_q[i] : 1'bz;
    end

    silpa_spi_master u_spim (
        .clk_i         (clk480),
        .rst_ni        (sys_rst_n),
        .start_i       (spim_start),
        .tx_data_i     (wdata_q),
        .length_i      (length_q),
        .cs_mask_i     (cs_mask_q),
        .cs_pol_i      (cs_pol_q),
        .clkdiv_i      (clkdiv_q),
        .offline_i     (offline_q),
        .cpol_i        (cpol_q),
        .cpha_i        (cpha_q),
        .lsb_first_i   (lsb_first),
        .half_duplex_i (hd_q),
        .end_i         (end_q),
        .miso_i        (spisdcard_miso),
        .idle_o        (spim_idle),
        .done_o        (spim_done),
        .rx_data_o     (spim_rx),
        .sck_o         (spisdcard_clk),
        .mosi_o        (spisdcard_mosi),
        .cs_n_o        (spisdcard_cs_n)
    );

    assign spi0_miso  = miso_q;
    assign user_led   = irq_q;
    assign user_led_1 = !spim_idle;
    assign user_led_2 = !cs_s;

endmodule

// File: tb/tb_silpa_fpga_core.sv
// tb/tb_silpa_fpga_core.sv - directed self-checking bench for silpa_fpga_core
module tb_silpa_fpga_core;

    logic clk = 1'b0, rst_n = 1'b0;
    logic sclk = 1'b0, smosi = 1'b0, scs_n = 1'b1;
    logic tb_oe = 1'b0;
    logic [15:0] tb_val = 16'h0000;
    wire  [15:0] slot_w;
    logic miso, led0, led1, led2, sd_clk, sd_mosi, sd_cs_n;

    int checks = 0, errors = 0;
    int sd_rise_cnt = 0, cs_fall_cnt = 0;
    logic [15:0] sd_word = 16'h0;
    time sd_last_t = 0, sd_prev_t = 0;

    assign slot_w = tb_oe ? tb_val : 16'hzzzz;

    always #1 clk = ~clk;

    silpa_fpga_core dut (
        .clk480         (clk),
        .sys_rst_n      (rst_n),
        .spi0_clk       (sclk),
        .spi0_mosi      (smosi),
        .spi0_miso      (miso),
        .spi0_cs_n      (scs_n),
        .slot           (slot_w),
        .user_led       (led0),
        .user_led_1     (led1),
        .user_led_2     (led2),
        .spisdcard_clk  (sd_clk),
        .spisdcard_mosi (sd_mosi),
        .spisdcard_cs_n (sd_cs_n),
        .spisdcard_miso (sd_mosi)
    );

    always @(posedge sd_clk) begin
        sd_rise_cnt <= sd_rise_cnt + 1;
        sd_word     <= {sd_word[14:0], sd_mosi};
        sd_prev_t   <= sd_last_t;
        sd_last_t   <= $time;
    end

    always @(negedge sd_cs_n) cs_fall_cnt <= cs_fall_cnt + 1;

    // host mode-0 frame; nrise < 32 aborts the frame by raising cs_n early
    task automatic spi_xfer(input logic [7:0] addr, input logic [15:0] wdata,
                            input int nrise, output logic [15:0] rdata);
        rdata = 16'h0;
        @(negedge clk);
        scs_n = 1'b0;
        #6;
        for (int i = 0; i < nrise; i++) begin
            if (i < 8)       smosi = addr[7-i];
            else if (i < 16) smosi = 1'b0;
            else             smosi = wdata[31-i];
            #6 sclk = 1'b1;
            #4 if (i >= 16) rdata[31-i] = miso;
            #2 sclk = 1'b0;
        end
        smosi = 1'b0;
        #6 scs_n = 1'b1;
        #18;
    endtask

    task automatic reg_wr(input logic [7:0] addr, input logic [15:0] data);
        logic [15:0] dummy;
        spi_xfer(addr, data, 32, dummy);
    endtask

    task automatic reg_rd(input logic [7:0] addr, output logic [15:0] data);
        spi_xfer(addr | 8'h80, 16'h0, 32, data);
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        #5;
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", miso); end
        checks++; if ({sd_clk, sd_mosi, sd_cs_n} !== 3'b001) begin errors++; $display("FAIL reset_sd_pins got %b want 001", {sd_clk, sd_mosi, sd_cs_n}); end
        checks++; if ({led0, led1, led2} !== 3'b000) begin errors++; $display("FAIL reset_leds got %b want 000", {led0, led1, led2}); end
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);
        reg_rd(8'h87, rd);
        checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL reset_clkdiv got %h want 0001", rd); end
        reg_rd(8'h80, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL reset_slot_out got %h want 0000", rd); end
    endtask

    task automatic test_slot_out_rw();
        logic [15:0] vals [7] = '{16'hAAAA, 16'h5555, 16'h0000, 16'h0001, 16'h8000, 16'hFFFF, 16'h2A2A};
        logic [15:0] rd;
        for (int i = 0; i < 7; i++) begin
            reg_wr(8'h00, vals[i]);
            reg_rd(8'h80, rd);
            checks++; if (rd !== vals[i]) begin errors++; $display("FAIL slot_out_rw[%0d] got %h want %h", i, rd, vals[i]); end
        end
    endtask

    task automatic test_gpio();
        logic [15:0] rd;
        reg_wr(8'h01, 16'hFFFF);
        reg_wr(8'h00, 16'h00F0);
        repeat (2) @(negedge clk);
        checks++; if (slot_w !== 16'h00F0) begin errors++; $display("FAIL gpio_drive got %h want 00f0", slot_w); end
        reg_wr(8'h01, 16'h0000);
        tb_oe = 1'b1; tb_val = 16'h1234;
        repeat (8) @(negedge clk);
        reg_rd(8'h82, rd);
        checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL gpio_in got %h want 1234", rd); end
        reg_rd(8'h80, rd);
        checks++; if (rd !== 16'h00F0) begin errors++; $display("FAIL gpio_out_readback got %h want 00f0", rd); end
        tb_oe = 1'b0;
    endtask

    task automatic test_config();
        logic [15:0] rd;
        logic [15:0] lsb_exp;
`ifdef SPIM_LSB_FIRST_EN
        lsb_exp = 16'h0001;
`else
        lsb_exp = 16'h0000;
`endif
        reg_wr(8'h04, 16'h000F);
        reg_wr(8'h05, 16'h0001);
        reg_wr(8'h06, 16'h0000);
        reg_wr(8'h07, 16'hFF04);
        reg_wr(8'h08, 16'h0000);
        reg_wr(8'h09, 16'h0000);
        reg_wr(8'h0A, 16'h0000);
        reg_wr(8'h0C, 16'h0000);
        reg_wr(8'h0D, 16'h0001);
        reg_wr(8'h0B, 16'h0001);
        reg_rd(8'h8B, rd);
        checks++; if (rd !== lsb_exp) begin errors++; $display("FAIL lsb_first_reg got %h want %h", rd, lsb_exp); end
        reg_wr(8'h0B, 16'h0000);
        reg_rd(8'h87, rd);
        checks++; if (rd !== 16'h0004) begin errors++; $display("FAIL clkdiv_width got %h want 0004", rd); end
        reg_rd(8'h84, rd);
        checks++; if (rd !== 16'h000F) begin errors++; $display("FAIL length got %h want 000f", rd); end
        reg_rd(8'h90, rd);
        checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL idle got %h want 0001", rd); end
        reg_rd(8'h8F, rd);
        checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL writable got %h want 0001", rd); end
    endtask

    task automatic test_transfer();
        logic [15:0] rd;
        int r0, f0;
        r0 = sd_rise_cnt;
        f0 = cs_fall_cnt;
        reg_wr(8'h03, 16'hAA55);
        for (int k = 0; k < 2000 && led0 !== 1'b1; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        checks++; if (led0 !== 1'b1) begin errors++; $display("FAIL xfer_irq_set got %b want 1", led0); end
        checks++; if (cs_fall_cnt - f0 != 1) begin errors++; $display("FAIL xfer_cs_falls got %0d want 1", cs_fall_cnt - f0); end
        checks++; if (sd_rise_cnt - r0 != 16) begin errors++; $display("FAIL xfer_sck_pulses got %0d want 16", sd_rise_cnt - r0); end
        checks++; if (sd_word !== 16'hAA55) begin errors++; $display("FAIL xfer_mosi_word got %h want aa55", sd_word); end
        checks++; if (sd_last_t - sd_prev_t != 64'd16) begin errors++; $display("FAIL xfer_sck_period got %0d want 16", sd_last_t - sd_prev_t); end
        checks++; if ({sd_cs_n, led1} !== 2'b10) begin errors++; $display("FAIL xfer_end_state got %b want 10", {sd_cs_n, led1}); end
        reg_rd(8'h83, rd);
        checks++; if (rd !== 16'hAA55) begin errors++; $display("FAIL xfer_rx got %h want aa55", rd); end
        checks++; if (led0 !== 1'b0) begin errors++; $display("FAIL xfer_irq_clear got %b want 0", led0); end
    endtask

    task automatic test_abort();
        logic [15:0] rd;
        reg_wr(8'h00, 16'h1111);
        spi_xfer(8'h00, 16'hBEEF, 28, rd);
        reg_rd(8'h80, rd);
        checks++; if (rd !== 16'h1111) begin errors++; $display("FAIL abort_discard got %h want 1111", rd); end
        reg_wr(8'h00, 16'hBEEF);
        reg_rd(8'h80, rd);
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL abort_recover got %h want beef", rd); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd;
        reg_wr(8'h03, 16'h1234);
        for (int k = 0; k < 500 && sd_cs_n !== 1'b0; k++) @(negedge clk);
        repeat (20) @(negedge clk);
        checks++; if ({sd_cs_n, led1} !== 2'b01) begin errors++; $display("FAIL mid_running got %b want 01", {sd_cs_n, led1}); end
        rst_n = 1'b0;
        #1;
        checks++; if ({sd_cs_n, sd_clk, led1} !== 3'b100) begin errors++; $display("FAIL mid_reset_pins got %b want 100", {sd_cs_n, sd_clk, led1}); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        reg_rd(8'h90, rd);
        checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL mid_idle got %h want 0001", rd); end
        reg_rd(8'h87, rd);
        checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL mid_clkdiv got %h want 0001", rd); end
    endtask

    initial begin
        test_reset();
        test_slot_out_rw();
        test_gpio();
        test_config();
        test_transfer();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
